// File: rtl/gray_step_sequencer_pkg.sv
// Shared types and default widths for the Gray step sequencer.
// Holds the FSM state encoding used by the top level.
package gray_seq_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/gray_step_sequencer_if.sv
// Command, pacing and status bundle between a control agent and the sequencer.
// The master drives commands and pacing; the slave (sequencer) reports status.
interface gray_step_sequencer_if #(
  parameter int data_width = 4,
  parameter int cnt_width  = 8
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_load;
  logic [data_width-1:0] cmd_start;
  logic [cnt_width-1:0]  cmd_steps;
  logic                  step_en;
  logic                  abort;
  logic [data_width-1:0] gray_out;
  logic [cnt_width-1:0]  steps_left;
  logic                  busy;
  logic                  done;
  logic                  wrap;

  modport master (
    output cmd_valid, cmd_load, cmd_start, cmd_steps, step_en, abort,
    input  cmd_ready, gray_out, steps_left, busy, done, wrap
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_start, cmd_steps, step_en, abort,
    output cmd_ready, gray_out, steps_left, busy, done, wrap
  );

endinterface

// File: rtl/gray_count_core.sv
// Binary counter with synchronous load/increment, Gray-coded output and
// a registered wrap pulse that lines up with the count showing zero.
module gray_count_core
  import gray_seq_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [data_width-1:0] i_load_val,
  input  logic                  i_inc,
  output logic [data_width-1:0] o_gray,
  output logic                  o_wrap
);

  logic [data_width-1:0] r_bin;
  logic                  r_wrap;

  // wrap is registered with the increment so it rises with the zero count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_wrap <= 1'b0;
    end else if (i_load) begin
      r_bin  <= i_load_val;
      r_wrap <= 1'b0;
    end else if (i_inc) begin
      r_bin  <= r_bin + 1'b1;
      r_wrap <= &r_bin;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_gray = r_bin ^ (r_bin >> 1);
  assign o_wrap = r_wrap;

endmodule

// File: rtl/gray_step_sequencer.sv
// Command-driven sequencer: accepts a command, optionally preloads the Gray
// counter, then advances it a programmed number of step_en-paced steps.
module gray_step_sequencer
  import gray_seq_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int cnt_width  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  gray_step_sequencer_if.slave bus
);

  seq_state_e           r_state;
  seq_state_e           w_next;
  logic [cnt_width-1:0] r_steps_left;
  logic [cnt_width-1:0] w_steps_nxt;
  logic                 w_load;
  logic                 w_inc;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state      <= ST_IDLE;
      r_steps_left <= '0;
    end else begin
      r_state      <= w_next;
      r_steps_left <= w_steps_nxt;
    end
  end

  // abort wins over step_en in RUN, so counter and steps_left both hold
  always_comb begin
    w_next      = r_state;
    w_steps_nxt = r_steps_left;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_steps_nxt = bus.cmd_steps;
          w_load      = bus.cmd_load;
          w_next      = (bus.cmd_steps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_next = ST_IDLE;
        end else if (bus.step_en) begin
          w_inc       = 1'b1;
          w_steps_nxt = r_steps_left - 1'b1;
          if (r_steps_left == cnt_width'(1)) w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  gray_count_core #(
    .data_width(data_width)
  ) u_core (
    .clk       (clk),
    .rst       (resetn),
    .i_load    (w_load),
    .i_load_val(bus.cmd_start),
    .i_inc     (w_inc),
    .o_gray    (bus.gray_out),
    .o_wrap    (bus.wrap)
  );

  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.steps_left = r_steps_left;

endmodule

// File: doc/gray_step_sequencer.md
# gray_step_sequencer

Command-driven controller that sequences a Gray-code counter. It accepts a command over a valid/ready handshake, optionally preloads a binary start value, and advances the counter a programmed number of steps paced by `step_en`. It reports progress, completion and wrap-around. It sits between a control agent (CPU register block or test sequencer) and any logic consuming the Gray-coded count, such as pointer generation or encoder stimulus.

## Interface
- `data_width`, default 4: Gray counter width.
- `cnt_width`, default 8: width of the step-count field.

- `clk`, in, 1: single clock; all state updates on its rising edge.
- `resetn`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_load`, in, 1: when 1, preload counter from `cmd_start`; when 0, continue from the current value.
- `cmd_start`, in, `data_width`: binary start value, used only when `cmd_load`=1.
- `cmd_steps`, in, `cnt_width`: number of increments to perform, 0 to 2^cnt_width−1.
- `step_en`, in, 1: pacing; one increment per RUN cycle in which it is high.
- `abort`, in, 1: terminate the command in progress.
- `gray_out`, out, `data_width`: Gray encoding of the internal binary count, computed as `bin ^ (bin >> 1)`.
- `steps_left`, out, `cnt_width`: remaining increments.
- `busy`, out, 1: high in RUN and DONE.
- `done`, out, 1: one-cycle pulse when a command completes normally.
- `wrap`, out, 1: one-cycle pulse when the count rolls from all-ones to zero.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid` && `cmd_ready`:
    - latch `steps_left` ← `cmd_steps`;
    - if `cmd_load`, set `bin` ← `cmd_start`;
    - go to RUN, or go directly to DONE if `cmd_steps`=0.
  - `abort` is ignored in IDLE.
- **RUN**
  - `cmd_ready`=0.
  - Each cycle with `step_en`=1 and `abort`=0:
    - `bin` ← `bin`+1, modulo 2^data_width;
    - `steps_left` ← `steps_left`−1.
  - When the decrement takes `steps_left` from 1 to 0, go to DONE.
  - `abort`=1 → IDLE on the next edge:
    - no step is taken that cycle, even if `step_en`=1;
    - `bin` holds its value;
    - `steps_left` holds its value;
    - `done` does not pulse.
- **DONE**
  - `done`=1 for exactly this one cycle, then IDLE unconditionally.
  - `abort` is ignored in DONE.
- Wrap: an increment from `bin` = all-ones produces `bin`=0 and `wrap`=1 in the cycle `gray_out` first shows 0.
- Commands arriving while `cmd_ready`=0 are not accepted; the requester must hold `cmd_valid`.

## Timing
- Reset values: state IDLE, `bin`=0, `gray_out`=0, `steps_left`=0, `cmd_ready`=1, `busy`=0, `done`=0, `wrap`=0.
- Reset mid-command returns all of the above immediately (asynchronous). No command survives reset.
- `gray_out` changes only on clock edges and by exactly one bit per step.
- Acceptance edge T:
  - RUN is visible from T+1;
  - the preloaded value is visible on `gray_out` from T+1.
- With `step_en` held at 1 and N ≥ 1:
  - steps occur at edges T+1 … T+N;
  - `done`=1 during cycle T+N+1;
  - `cmd_ready`=1 again from T+N+2.
- `cmd_steps`=0: `done` during T+1, ready again at T+2, counter unchanged except for the preload.
- Throughput: one command per N+2 cycles minimum.

## Structure
- Shared package `gray_seq_pkg` holds:
  - the FSM state enum (IDLE=0, RUN=1, DONE=2, 2-bit encoding);
  - the default width constants.
- One natural sub-module, `gray_count_core`. It contains:
  - the binary register with synchronous load and enable;
  - the Gray conversion;
  - wrap detection.
- The FSM, handshake and step counter stay in the top level.

## Test plan
- Reset, then command load=1, start=0, steps=5, `step_en`=1 → `gray_out` sequence 0,1,3,2,6,7; `done` pulses at T+6; `cmd_ready` high at T+7.
- Command load=1, start=14, steps=3 at `data_width`=4 → `gray_out` 9,8,0,1; `wrap`=1 only in the cycle showing 0.
- Command steps=4 with `step_en` toggling 1,0,1,0,… → only enabled cycles step; `steps_left` decrements 4,3,3,2,2,1,1,0; `done` follows the final step by one cycle.
- Abort in the same cycle as the last enabled step (steps_left=1) → no step taken; back to IDLE; `done` never pulses; `steps_left`=1 retained.
- Command steps=0, load=1, start=5 → `gray_out`=7 from T+1; `done` at T+1; no step occurs.
- Assert reset during RUN after 2 of 6 steps → `gray_out`=0, `busy`=0, `cmd_ready`=1 immediately; a follow-up command with load=0, steps=1 yields `gray_out`=1.
